// File: rtl/fetch_queue.sv
// Instruction fetch queue: requests 4-word bundles from four parallel ROMs
// and buffers them. The CPU can dequeue up to two instructions per cycle.
// A redirect flushes the queue and restarts fetch at the new address.
module fetch_queue #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic [ADDR_WIDTH-1:0]    rom_addr_o,
    input  logic [INSTR_WIDTH-1:0]   inst_0_i,
    input  logic [INSTR_WIDTH-1:0]   inst_1_i,
    input  logic [INSTR_WIDTH-1:0]   inst_2_i,
    input  logic [INSTR_WIDTH-1:0]   inst_3_i,
    input  logic                     redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_addr_i,
    output logic                     deq_valid_0_o,
    output logic                     deq_valid_1_o,
    output logic [INSTR_WIDTH-1:0]   deq_inst_0_o,
    output logic [INSTR_WIDTH-1:0]   deq_inst_1_o,
    output logic [ADDR_WIDTH-1:0]    deq_pc_0_o,
    output logic [ADDR_WIDTH-1:0]    deq_pc_1_o,
    input  logic [1:0]               deq_count_i,
    output logic [$clog2(DEPTH):0]   q_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc_q;
    logic [ADDR_WIDTH-1:0]  pend_addr_q;
    logic                   pending_q;
    logic [PW-1:0]          head_q;
    logic [PW-1:0]          tail_q;
    logic [CW-1:0]          count_q;

    logic [INSTR_WIDTH-1:0] inst_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem_q   [DEPTH];

    logic [CW:0]            fill_level;
    logic                   issue;
    logic                   enq;
    logic [1:0]             avail;
    logic [1:0]             deq_req;
    logic [1:0]             deq_eff;
    logic [PW-1:0]          head_p1;

    // Occupancy including the in-flight bundle decides whether another fits.
    always_comb begin
        fill_level = {1'b0, count_q} + (pending_q ? (CW+1)'(4) : (CW+1)'(0));
        issue      = !redirect_valid_i && (fill_level <= (CW+1)'(DEPTH - 4));
        enq        = pending_q && !redirect_valid_i;
        avail      = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        deq_req    = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;
        deq_eff    = (deq_req < avail) ? deq_req : avail;
        head_p1    = head_q + PW'(1);
    end

    assign rom_addr_o    = fetch_pc_q;
    assign deq_valid_0_o = (count_q >= CW'(1));
    assign deq_valid_1_o = (count_q >= CW'(2));
    assign deq_inst_0_o  = inst_mem_q[head_q];
    assign deq_inst_1_o  = inst_mem_q[head_p1];
    assign deq_pc_0_o    = pc_mem_q[head_q];
    assign deq_pc_1_o    = pc_mem_q[head_p1];
    assign q_count_o     = count_q;

    // Fetch control and queue bookkeeping; reset beats redirect, redirect beats everything else.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q  <= '0;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (redirect_valid_i) begin
            fetch_pc_q  <= redirect_addr_i;
            pending_q   <= 1'b0;
            head_q      <= tail_q;
            count_q     <= '0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                pend_addr_q <= fetch_pc_q;
                fetch_pc_q  <= fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (enq) begin
                tail_q <= tail_q + PW'(4);
            end
            head_q  <= head_q + PW'(deq_eff);
            count_q <= count_q + (enq ? CW'(4) : CW'(0)) - CW'(deq_eff);
        end
    end

    // Returning bundle lands in four consecutive slots at the tail.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            inst_mem_q[tail_q]          <= inst_0_i;
            inst_mem_q[tail_q + PW'(1)] <= inst_1_i;
            inst_mem_q[tail_q + PW'(2)] <= inst_2_i;
            inst_mem_q[tail_q + PW'(3)] <= inst_3_i;
            pc_mem_q[tail_q]            <= pend_addr_q;
            pc_mem_q[tail_q + PW'(1)]   <= pend_addr_q + ADDR_WIDTH'(1);
            pc_mem_q[tail_q + PW'(2)]   <= pend_addr_q + ADDR_WIDTH'(2);
            pc_mem_q[tail_q + PW'(3)]   <= pend_addr_q + ADDR_WIDTH'(3);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a ROM model and a PC scoreboard.
module tb_fetch_queue;

    localparam int IW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] inst_0, inst_1, inst_2, inst_3;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          deq_valid_0, deq_valid_1;
    logic [IW-1:0] deq_inst_0, deq_inst_1;
    logic [AW-1:0] deq_pc_0, deq_pc_1;
    logic [1:0]    deq_count;
    logic [CW-1:0] q_count;

    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0] sb [$];

    always #5 clk = ~clk;

    fetch_queue #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .rom_addr_o       (rom_addr),
        .inst_0_i         (inst_0),
        .inst_1_i         (inst_1),
        .inst_2_i         (inst_2),
        .inst_3_i         (inst_3),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .deq_valid_0_o    (deq_valid_0),
        .deq_valid_1_o    (deq_valid_1),
        .deq_inst_0_o     (deq_inst_0),
        .deq_inst_1_o     (deq_inst_1),
        .deq_pc_0_o       (deq_pc_0),
        .deq_pc_1_o       (deq_pc_1),
        .deq_count_i      (deq_count),
        .q_count_o        (q_count)
    );

    // ROM word content: a tag in the upper bits so data never equals its PC.
    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        return {6'b101001, a};
    endfunction

    // Four ROMs with one-cycle read latency.
    always @(posedge clk) begin
        inst_0 <= rom(rom_addr);
        inst_1 <= rom(rom_addr + AW'(1));
        inst_2 <= rom(rom_addr + AW'(2));
        inst_3 <= rom(rom_addr + AW'(3));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_start(input logic [AW-1:0] addr);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(addr + AW'(i));
    endtask

    task automatic peek2();
        chk("peek_pc_0", deq_pc_0, sb[0]);
        chk("peek_inst_0", deq_inst_0, rom(sb[0]));
        chk("peek_pc_1", deq_pc_1, sb[1]);
        chk("peek_inst_1", deq_inst_1, rom(sb[1]));
    endtask

    // Check the n entries about to be consumed against the scoreboard, then pop them.
    task automatic take(input int n);
        if (sb.size() < n) begin
            chk("sb_underrun", sb.size(), n);
        end else begin
            if (n >= 1) begin
                chk("deq_pc_0", deq_pc_0, sb[0]);
                chk("deq_inst_0", deq_inst_0, rom(sb[0]));
            end
            if (n == 2) begin
                chk("deq_pc_1", deq_pc_1, sb[1]);
                chk("deq_inst_1", deq_inst_1, rom(sb[1]));
            end
            for (int i = 0; i < n; i++) void'(sb.pop_front());
        end
    endtask

    task automatic cyc(input logic [1:0] d, input int n);
        take(n);
        deq_count = d;
        step();
        deq_count = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        deq_count      = 2'd0;
        repeat (3) step();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_valid_0", deq_valid_0, 0);
        chk("rst_valid_1", deq_valid_1, 0);

        // Cold start
        reset = 1'b0;
        sb_start('0);
        chk("cold_rom_addr_0", rom_addr, 0);
        step();
        chk("cold_rom_addr_4", rom_addr, 4);
        chk("cold_q_count_c1", q_count, 0);
        chk("cold_valid_c1", deq_valid_0, 0);
        step();
        chk("cold_rom_addr_8", rom_addr, 8);
        chk("cold_q_count_c2", q_count, 4);
        chk("cold_valid0_c2", deq_valid_0, 1);
        chk("cold_valid1_c2", deq_valid_1, 1);
        step();
        chk("cold_q_count_c3", q_count, 8);
        chk("cold_rom_addr_c3", rom_addr, 8);
        step();
        chk("cold_q_count_hold", q_count, 8);
        chk("cold_rom_addr_hold", rom_addr, 8);

        // Steady stream, two per cycle
        for (int i = 0; i < 12; i++) begin
            chk("stream_valid_0", deq_valid_0, 1);
            chk("stream_valid_1", deq_valid_1, 1);
            cyc(2'd2, 2);
            chk("stream_q_le_depth", (q_count <= CW'(DEPTH)), 1);
        end
        step();
        chk("pre_redir_q_count", q_count, 4);

        // Redirect with a bundle in flight; deq_count must be ignored
        redirect_valid = 1'b1;
        redirect_addr  = 10'h105;
        deq_count      = 2'd2;
        step();
        redirect_valid = 1'b0;
        deq_count      = 2'd0;
        sb_start(10'h105);
        chk("redir_q_count", q_count, 0);
        chk("redir_rom_addr", rom_addr, 10'h105);
        chk("redir_valid_r0", deq_valid_0, 0);
        step();
        chk("redir_rom_addr_r1", rom_addr, 10'h109);
        chk("redir_valid_r1", deq_valid_0, 0);
        chk("redir_q_count_r1", q_count, 0);
        step();
        chk("redir_valid_r2", deq_valid_0, 1);
        chk("redir_q_count_r2", q_count, 4);
        peek2();
        step();
        chk("redir_q_count_r3", q_count, 8);
        cyc(2'd2, 2);
        chk("redir_q_count_r4", q_count, 6);
        cyc(2'd2, 2);
        chk("redir_q_count_r5", q_count, 4);
        cyc(2'd2, 2);
        chk("redir_q_count_r6", q_count, 2);
        cyc(2'd2, 2);
        chk("enq_deq_same_cycle", q_count, 4);

        // Address wrap-around
        redirect_valid = 1'b1;
        redirect_addr  = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        sb_start(10'h3FE);
        chk("wrap_rom_addr_w0", rom_addr, 10'h3FE);
        chk("wrap_q_count_w0", q_count, 0);
        step();
        chk("wrap_rom_addr_w1", rom_addr, 10'h002);
        step();
        chk("wrap_q_count_w2", q_count, 4);
        cyc(2'd2, 2);
        chk("wrap_q_count_w3", q_count, 6);
        cyc(2'd2, 2);
        chk("wrap_q_count_w4", q_count, 4);
        cyc(2'd2, 2);
        chk("wrap_q_count_w5", q_count, 2);
        cyc(2'd1, 1);
        chk("single_deq_q_count", q_count, 5);
        cyc(2'd2, 2);
        chk("wrap_q_count_w7", q_count, 3);
        cyc(2'd2, 2);
        chk("clamp_pre_q_count", q_count, 1);
        chk("clamp_pre_valid_0", deq_valid_0, 1);
        chk("clamp_pre_valid_1", deq_valid_1, 0);
        cyc(2'd2, 1);
        chk("clamp_post_q_count", q_count, 4);
        chk("clamp_post_valid_1", deq_valid_1, 1);
        chk("clamp_post_pc_0", deq_pc_0, sb[0]);

        // Reset mid-operation, with a concurrent redirect that must lose
        step();
        chk("pre_reset_q_count", q_count, 4);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 10'h155;
        step();
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_q_count", q_count, 0);
        chk("midrst_valid_0", deq_valid_0, 0);
        chk("midrst_valid_1", deq_valid_1, 0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        sb_start('0);
        chk("restart_rom_addr_0", rom_addr, 0);
        step();
        chk("restart_rom_addr_4", rom_addr, 4);
        step();
        chk("restart_q_count", q_count, 4);
        peek2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
